// File: rtl/render_arbiter_pkg.sv
// Shared types and constants for the renderer write-port arbiter.
// Screen coordinates, state encoding and a range-check helper.
package render_arbiter_pkg;

    localparam int unsigned DEF_SCREEN_W = 320;
    localparam int unsigned DEF_SCREEN_H = 240;

    localparam int unsigned X_W     = 9;
    localparam int unsigned Y_W     = 8;
    localparam int unsigned XY_W    = X_W + Y_W;
    localparam int unsigned COLOR_W = 3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } screenXY;

    typedef enum logic [1:0] {
        WAIT_ACK = 2'd0,
        RENDER   = 2'd1,
        FLUSH    = 2'd2,
        ISSUE    = 2'd3
    } rarb_state_t;

    function automatic logic xy_in_range(
        input screenXY     c,
        input int unsigned w,
        input int unsigned h
    );
        return (int'(c.x) < int'(w)) && (int'(c.y) < int'(h));
    endfunction

endpackage

// File: rtl/render_arbiter_rr_arbiter.sv
// N-input round-robin arbiter: search starts at ptr_i, wraps once.
// Emits one-hot grant, winner index and the pointer past the winner.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] win_o,
    output logic [PW-1:0] ptr_o,
    output logic          valid_o
);

    function automatic int wrap(input int v);
        return v % int'(N);
    endfunction

    // Scan clients starting at the pointer; first requester wins
    always_comb begin
        gnt_o   = '0;
        win_o   = ptr_i;
        ptr_o   = ptr_i;
        valid_o = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (!valid_o && req_i[wrap(int'(ptr_i) + k)]) begin
                gnt_o[wrap(int'(ptr_i) + k)] = 1'b1;
                win_o   = PW'(wrap(int'(ptr_i) + k));
                ptr_o   = PW'(wrap(int'(ptr_i) + k + 1));
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/render_arbiter.sv
// Shares the framebuffer renderer write port among rendering clients.
// Sequences frames: ack -> frame_start -> arbitrated writes -> done.
module render_arbiter
    import render_arbiter_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 3,
    parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H  = DEF_SCREEN_H
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_CLIENTS-1:0]         client_req_i,
    input  logic [N_CLIENTS*XY_W-1:0]    client_coords_i,
    input  logic [N_CLIENTS*COLOR_W-1:0] client_color_i,
    input  logic [N_CLIENTS-1:0]         client_done_i,
    input  logic [N_CLIENTS-1:0]         client_enable_i,
    output logic [N_CLIENTS-1:0]         client_gnt_o,
    output logic                         frame_start_o,
    output logic [XY_W-1:0]              fb_coords_o,
    output logic [COLOR_W-1:0]           fb_color_o,
    output logic                         fb_render_done_o,
    input  logic                         fb_render_ack_i,
    output logic                         oob_drop_o,
    output logic                         busy_o
);

    localparam int unsigned PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    rarb_state_t          state_q, state_d;
    logic [N_CLIENTS-1:0] mask_q, mask_d;
    logic [N_CLIENTS-1:0] done_q, done_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 fstart_q, fstart_d;
    screenXY              fb_xy_q, fb_xy_d;
    logic [COLOR_W-1:0]   fb_col_q, fb_col_d;
    logic                 oob_q, oob_d;

    logic [N_CLIENTS-1:0] elig;
    logic [N_CLIENTS-1:0] gnt;
    logic [PW-1:0]        win;
    logic [PW-1:0]        ptr_nxt;
    logic                 gnt_any;
    screenXY              win_xy;
    logic [COLOR_W-1:0]   win_col;

    // Only unmasked, not-yet-done requesters compete, and only in RENDER
    always_comb begin
        elig = '0;
        if (state_q == RENDER) begin
            elig = client_req_i & mask_q & ~done_q;
        end
    end

    rr_arbiter #(
        .N  (N_CLIENTS),
        .PW (PW)
    ) u_rr (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .win_o   (win),
        .ptr_o   (ptr_nxt),
        .valid_o (gnt_any)
    );

    assign win_xy  = client_coords_i[int'(win)*XY_W +: XY_W];
    assign win_col = client_color_i[int'(win)*COLOR_W +: COLOR_W];

    // Next-state and next-output computation for the frame sequencer
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        done_d   = done_q;
        ptr_d    = ptr_q;
        fstart_d = 1'b0;
        fb_xy_d  = fb_xy_q;
        fb_col_d = fb_col_q;
        oob_d    = 1'b0;
        unique case (state_q)
            WAIT_ACK: begin
                if (fb_render_ack_i) begin
                    mask_d   = client_enable_i;
                    done_d   = ~client_enable_i;
                    fstart_d = 1'b1;
                    state_d  = RENDER;
                end
            end
            RENDER: begin
                done_d = done_q | client_done_i;
                if (gnt_any) begin
                    ptr_d = ptr_nxt;
                    if (xy_in_range(win_xy, SCREEN_W, SCREEN_H)) begin
                        fb_xy_d  = win_xy;
                        fb_col_d = win_col;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
                if (&done_d) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            default: begin
                state_d = WAIT_ACK;
            end
        endcase
    end

    // State and registered outputs with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WAIT_ACK;
            mask_q   <= '0;
            done_q   <= '0;
            ptr_q    <= '0;
            fstart_q <= 1'b0;
            fb_xy_q  <= '0;
            fb_col_q <= '0;
            oob_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            ptr_q    <= ptr_d;
            fstart_q <= fstart_d;
            fb_xy_q  <= fb_xy_d;
            fb_col_q <= fb_col_d;
            oob_q    <= oob_d;
        end
    end

    assign client_gnt_o     = gnt;
    assign frame_start_o    = fstart_q;
    assign fb_coords_o      = fb_xy_q;
    assign fb_color_o       = fb_col_q;
    assign fb_render_done_o = (state_q == ISSUE);
    assign oob_drop_o       = oob_q;
    assign busy_o           = (state_q != WAIT_ACK);

endmodule

// File: tb/tb_render_arbiter.sv
// Directed bench for render_arbiter with hand-computed expectations.
// Covers frame sequencing, round-robin order, OOB drop and reset.
module tb_render_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [50:0] coords;
    logic [8:0]  color;
    logic [2:0]  done;
    logic [2:0]  en;
    logic [2:0]  gnt;
    logic        fstart;
    logic [16:0] fb_xy;
    logic [2:0]  fb_col;
    logic        rdone;
    logic        ack;
    logic        oob;
    logic        busy;

    int n_vec;
    int n_bad;

    render_arbiter #(
        .N_CLIENTS (3),
        .SCREEN_W  (320),
        .SCREEN_H  (240)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .client_req_i     (req),
        .client_coords_i  (coords),
        .client_color_i   (color),
        .client_done_i    (done),
        .client_enable_i  (en),
        .client_gnt_o     (gnt),
        .frame_start_o    (fstart),
        .fb_coords_o      (fb_xy),
        .fb_color_o       (fb_col),
        .fb_render_done_o (rdone),
        .fb_render_ack_i  (ack),
        .oob_drop_o       (oob),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] xy(input int x, input int y);
        return {9'(x), 8'(y)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input int x, input int y,
                           input int c);
        coords[i*17 +: 17] = xy(x, y);
        color[i*3 +: 3]    = 3'(c);
    endtask

    task automatic std_pix();
        for (int i = 0; i < 3; i++) begin
            set_pix(i, 10 + i, 20 + i, i + 1);
        end
    endtask

    // One frame with no grants expected; done pulses at cycles ca/cb
    task automatic frame_seq(
        input logic [2:0] m,
        input logic [2:0] rq,
        input int         ca,
        input logic [2:0] da,
        input int         cb,
        input logic [2:0] db,
        input int         ic,
        input int         nc
    );
        en  = m;
        req = rq;
        ack = 1'b1;
        step();
        ack = 1'b0;
        for (int c = 1; c <= nc; c++) begin
            done = (c == ca) ? da : ((c == cb) ? db : 3'b000);
            check($sformatf("fs_start_c%0d", c), 32'(fstart),
                  32'(c == 1));
            check($sformatf("fs_rdone_c%0d", c), 32'(rdone),
                  32'(c == ic));
            check($sformatf("fs_busy_c%0d", c), 32'(busy),
                  32'(c <= ic));
            #1;
            check($sformatf("fs_gnt_c%0d", c), 32'(gnt), 32'd0);
            step();
        end
        done = '0;
        req  = '0;
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        req    = '0;
        coords = '0;
        color  = '0;
        done   = '0;
        en     = '0;
        ack    = 1'b0;
        n_vec  = 0;
        n_bad  = 0;

        step();
        step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_fstart", 32'(fstart), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fbxy", 32'(fb_xy), 32'd0);
        check("rst_fbcol", 32'(fb_col), 32'd0);
        check("rst_rdone", 32'(rdone), 32'd0);
        check("rst_oob", 32'(oob), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Frame 1: all clients, round-robin order
        en  = 3'b111;
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("f1_fstart", 32'(fstart), 32'd1);
        check("f1_busy", 32'(busy), 32'd1);
        check("f1_fbxy0", 32'(fb_xy), 32'd0);
        check("f1_fbcol0", 32'(fb_col), 32'd0);
        std_pix();
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_gnt%0d", k), 32'(gnt),
                  32'(1 << (k % 3)));
            step();
            check($sformatf("rr_xy%0d", k), 32'(fb_xy),
                  32'(xy(10 + k % 3, 20 + k % 3)));
            check($sformatf("rr_col%0d", k), 32'(fb_col),
                  32'(k % 3 + 1));
        end
        check("f1_fstart_lo", 32'(fstart), 32'd0);

        // Out-of-range write from client 1
        req = 3'b010;
        set_pix(1, 320, 10, 7);
        #1;
        check("oob_gnt", 32'(gnt), 32'b010);
        step();
        check("oob_pulse", 32'(oob), 32'd1);
        check("oob_xy_hold", 32'(fb_xy), 32'(xy(12, 22)));
        check("oob_col_hold", 32'(fb_col), 32'd3);
        req = 3'b000;
        step();
        check("oob_lo", 32'(oob), 32'd0);

        // Client 0: done and request in the same cycle
        req  = 3'b001;
        done = 3'b001;
        set_pix(0, 5, 6, 5);
        #1;
        check("dq_gnt", 32'(gnt), 32'b001);
        step();
        done = 3'b000;
        check("dq_xy", 32'(fb_xy), 32'(xy(5, 6)));
        #1;
        check("dq_blocked", 32'(gnt), 32'd0);
        step();
        std_pix();
        req  = 3'b111;
        done = 3'b110;
        #1;
        check("end_gnt", 32'(gnt), 32'b010);
        step();
        done = 3'b000;
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_rdone", 32'(rdone), 32'd0);
        check("flush_xy", 32'(fb_xy), 32'(xy(11, 21)));
        #1;
        check("flush_gnt", 32'(gnt), 32'd0);
        step();
        check("issue_rdone", 32'(rdone), 32'd1);
        check("issue_busy", 32'(busy), 32'd1);
        step();
        req = 3'b000;
        check("wait_rdone", 32'(rdone), 32'd0);
        check("wait_busy", 32'(busy), 32'd0);
        check("wait_fstart", 32'(fstart), 32'd0);

        // Frame 2: mask 101, done at cycles 5 and 9
        frame_seq(3'b101, 3'b010, 5, 3'b001, 9, 3'b100, 11, 12);

        // Frame 3: empty mask ends immediately
        frame_seq(3'b000, 3'b111, 0, 3'b000, 0, 3'b000, 3, 4);

        // Frame 4: asynchronous reset in the middle of RENDER
        en  = 3'b111;
        ack = 1'b1;
        step();
        ack = 1'b0;
        std_pix();
        req = 3'b111;
        #1;
        check("r4_gnt_a", 32'(gnt), 32'b100);
        step();
        check("r4_xy_a", 32'(fb_xy), 32'(xy(12, 22)));
        #1;
        check("r4_gnt_b", 32'(gnt), 32'b001);
        step();
        check("r4_xy_b", 32'(fb_xy), 32'(xy(10, 20)));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_xy", 32'(fb_xy), 32'd0);
        check("arst_col", 32'(fb_col), 32'd0);
        check("arst_fstart", 32'(fstart), 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rdone_a", 32'(rdone), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        step();
        check("post_rdone_b", 32'(rdone), 32'd0);
        check("post_gnt", 32'(gnt), 32'd0);

        ack = 1'b1;
        step();
        ack = 1'b0;
        check("nf_fstart", 32'(fstart), 32'd1);
        done = 3'b111;
        #1;
        check("nf_gnt_ptr0", 32'(gnt), 32'b001);
        step();
        done = 3'b000;
        req  = 3'b000;
        check("nf_flush_rdone", 32'(rdone), 32'd0);
        check("nf_xy", 32'(fb_xy), 32'(xy(10, 20)));
        step();
        check("nf_issue_rdone", 32'(rdone), 32'd1);
        step();
        check("nf_end_rdone", 32'(rdone), 32'd0);
        check("nf_end_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
